param_cache: RTL and testbench

//  Parametrised direct-mapped write-through cache between one CPU port and the memory/coherence controller.

---
 rtl/param_cache_if.sv | 39 +++
 rtl/param_cache.sv | 188 ++++++++++++++++++
 tb/tb_param_cache.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_cache_if.sv
// CPU, snoop and memory-side signals of param_cache bundled as one interface.
// The cache uses the slave modport; the CPU/controller side uses master.
interface param_cache_if #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned WORDS_PER_LINE = 2,
    parameter int unsigned STATS_WIDTH    = 16
);
    localparam int unsigned LINE_WIDTH = DATA_WIDTH * WORDS_PER_LINE;
    localparam int unsigned REQ_WIDTH  = 1 + DATA_WIDTH + ADDR_WIDTH;

    logic [REQ_WIDTH-1:0]   cpu_request;
    logic                   cpu_request_ready;
    logic                   cpu_busy;
    logic [ADDR_WIDTH-1:0]  invalidate_address;
    logic                   invalidate_valid;
    logic [REQ_WIDTH-1:0]   memory_request;
    logic                   memory_request_ready;
    logic [LINE_WIDTH-1:0]  memory_response;
    logic                   memory_response_ready;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   data_out_ready;
    logic [STATS_WIDTH-1:0] hit_count;
    logic [STATS_WIDTH-1:0] miss_count;

    modport slave (
        input  cpu_request, cpu_request_ready, invalidate_address, invalidate_valid,
               memory_response, memory_response_ready,
        output cpu_busy, memory_request, memory_request_ready, data_out, data_out_ready,
               hit_count, miss_count
    );

    modport master (
        output cpu_request, cpu_request_ready, invalidate_address, invalidate_valid,
               memory_response, memory_response_ready,
        input  cpu_busy, memory_request, memory_request_ready, data_out, data_out_ready,
               hit_count, miss_count
    );
endinterface

// File: rtl/param_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with snoop invalidation.
// Define CACHE_STATS_EN to enable saturating hit/miss counters.
module param_cache #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned WORDS_PER_LINE = 2,
    parameter int unsigned LINE_COUNT     = 128,
    parameter int unsigned STATS_WIDTH    = 16
) (
    input logic          clock,
    input logic          reset,
    param_cache_if.slave cache_io
);
    localparam int unsigned OFFSET_BITS = $clog2(WORDS_PER_LINE);
    localparam int unsigned INDEX_BITS  = $clog2(LINE_COUNT);
    localparam int unsigned TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned REQ_WIDTH   = 1 + DATA_WIDTH + ADDR_WIDTH;

    typedef logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_t;
    typedef enum logic [1:0] {StIdle, StLookup, StReadWait, StWriteWait} state_e;

    state_e                state_q, state_d;
    logic [REQ_WIDTH-1:0]  req_q, req_d;
    logic [LINE_COUNT-1:0] valid_q, valid_d;
    logic                  fill_kill_q, fill_kill_d;
    logic [REQ_WIDTH-1:0]  mem_req_q, mem_req_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_out_valid_q, data_out_valid_d;

    logic [TAG_BITS-1:0]   tag_q [LINE_COUNT];
    line_t                 line_q [LINE_COUNT];

    logic                   req_write;
    logic [DATA_WIDTH-1:0]  req_data;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [TAG_BITS-1:0]    req_tag, inv_tag;
    logic [INDEX_BITS-1:0]  req_idx, inv_idx;
    logic [OFFSET_BITS-1:0] req_off;
    logic                   inv_hit, inv_req_match, lookup_hit;
    logic                   fill_en, write_en;
    line_t                  resp_line;

    assign {req_write, req_data, req_addr} = req_q;
    assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_idx   = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_off   = req_addr[OFFSET_BITS-1:0];
    assign inv_tag   = cache_io.invalidate_address[ADDR_WIDTH-1 -: TAG_BITS];
    assign inv_idx   = cache_io.invalidate_address[OFFSET_BITS +: INDEX_BITS];
    assign resp_line = line_t'(cache_io.memory_response);

    assign inv_hit = cache_io.invalidate_valid && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);
    // Snoop aimed at the line currently being fetched, which is not yet resident.
    assign inv_req_match = cache_io.invalidate_valid && (inv_idx == req_idx) && (inv_tag == req_tag);
    // A same-cycle invalidate of the looked-up line wins over the hit.
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) &&
                        !(inv_hit && (inv_idx == req_idx));

    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        valid_d          = valid_q;
        fill_kill_d      = fill_kill_q;
        mem_req_d        = mem_req_q;
        mem_req_valid_d  = mem_req_valid_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        fill_en          = 1'b0;
        write_en         = 1'b0;

        if (inv_hit) valid_d[inv_idx] = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cache_io.cpu_request_ready) begin
                    req_d   = cache_io.cpu_request;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                fill_kill_d = 1'b0;
                if (req_write) begin
                    write_en        = lookup_hit;
                    mem_req_d       = req_q;
                    mem_req_valid_d = 1'b1;
                    state_d         = StWriteWait;
                end else if (lookup_hit) begin
                    data_out_d       = line_q[req_idx][req_off];
                    data_out_valid_d = 1'b1;
                    state_d          = StIdle;
                end else begin
                    mem_req_d       = {1'b0, {DATA_WIDTH{1'b0}}, req_addr};
                    mem_req_valid_d = 1'b1;
                    state_d         = StReadWait;
                end
            end
            StReadWait: begin
                if (inv_req_match) fill_kill_d = 1'b1;
                if (cache_io.memory_response_ready) begin
                    fill_en          = 1'b1;
                    valid_d[req_idx] = !(fill_kill_q || inv_req_match ||
                                         (inv_hit && (inv_idx == req_idx)));
                    data_out_d       = resp_line[req_off];
                    data_out_valid_d = 1'b1;
                    mem_req_valid_d  = 1'b0;
                    state_d          = StIdle;
                end
            end
            StWriteWait: begin
                if (cache_io.memory_response_ready) begin
                    data_out_valid_d = 1'b1;
                    mem_req_valid_d  = 1'b0;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= StIdle;
            req_q            <= '0;
            valid_q          <= '0;
            fill_kill_q      <= 1'b0;
            mem_req_q        <= '0;
            mem_req_valid_q  <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            valid_q          <= valid_d;
            fill_kill_q      <= fill_kill_d;
            mem_req_q        <= mem_req_d;
            mem_req_valid_q  <= mem_req_valid_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    // Tag/data arrays need no reset; residency is governed by valid_q alone.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_q[req_idx]  <= req_tag;
            line_q[req_idx] <= resp_line;
        end else if (write_en) begin
            line_q[req_idx][req_off] <= req_data;
        end
    end

    assign cache_io.cpu_busy             = (state_q != StIdle);
    assign cache_io.memory_request       = mem_req_q;
    assign cache_io.memory_request_ready = mem_req_valid_q;
    assign cache_io.data_out             = data_out_q;
    assign cache_io.data_out_ready       = data_out_valid_q;

`ifdef CACHE_STATS_EN
    logic [STATS_WIDTH-1:0] hit_count_q, hit_count_d;
    logic [STATS_WIDTH-1:0] miss_count_q, miss_count_d;
    logic                   lookup_done;

    assign lookup_done = (state_q == StLookup);

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (lookup_done && lookup_hit && (hit_count_q != '1)) hit_count_d = hit_count_q + 1'b1;
        if (lookup_done && !lookup_hit && (miss_count_q != '1)) miss_count_d = miss_count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign cache_io.hit_count  = hit_count_q;
    assign cache_io.miss_count = miss_count_q;
`else
    assign cache_io.hit_count  = {STATS_WIDTH{1'b0}};
    assign cache_io.miss_count = {STATS_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache: directed vector table, hand-written snoop/reset sequences, then
// random traffic checked against a line-residency model and a byte-array backing memory.
module tb_param_cache;
    localparam int unsigned AW = 16, DW = 8, WPL = 2, LC = 128, SW = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    param_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .STATS_WIDTH(SW))
        bus_if ();

    param_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .LINE_COUNT(LC),
                  .STATS_WIDTH(SW)) dut (
        .clock    (clock),
        .reset    (reset),
        .cache_io (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: backing memory plus which line address each slot holds.
    logic [7:0] mem [65536];
    bit         m_valid [128];
    logic [7:0] m_tag [128];
    logic [7:0] m_line [128][2];
    logic [7:0] last_dout;
    int         m_hits, m_misses;

    typedef struct {
        bit          wr;
        logic [7:0]  d;
        logic [15:0] a;
        int          lat;
        bit          exp_hit;
        logic [7:0]  exp_data;
        logic [24:0] exp_req;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_stats(input string nm);
`ifdef CACHE_STATS_EN
        check({nm, "_hits"}, 64'(bus_if.hit_count), 64'(m_hits));
        check({nm, "_misses"}, 64'(bus_if.miss_count), 64'(m_misses));
`else
        check({nm, "_hits"}, 64'(bus_if.hit_count), 64'd0);
        check({nm, "_misses"}, 64'(bus_if.miss_count), 64'd0);
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        last_dout = 8'h00;
        m_hits    = 0;
        m_misses  = 0;
    endtask

    // One idle-cycle snoop; the model drops the line only on an exact index+tag match.
    task automatic snoop(input logic [15:0] a);
        bus_if.invalidate_address = a;
        bus_if.invalidate_valid   = 1'b1;
        @(negedge clock);
        bus_if.invalidate_valid = 1'b0;
        if (m_valid[a[7:1]] && m_tag[a[7:1]] == a[15:8]) m_valid[a[7:1]] = 1'b0;
    endtask

    // mode: 0 none, 1 snoop same address in first wait cycle, 2 snoop with the response,
    // 3 snoop same address during LOOKUP.
    task automatic transact(input string nm, input bit wr, input logic [7:0] d,
                            input logic [15:0] a, input int lat, input int mode,
                            input bit exp_hit, input logic [7:0] exp_data,
                            input logic [24:0] exp_req);
        logic [6:0] idx;
        bit         hit;
        idx = a[7:1];
        check({nm, "_idle"}, 64'(bus_if.cpu_busy), 64'd0);
        bus_if.cpu_request       = {wr, d, a};
        bus_if.cpu_request_ready = 1'b1;
        @(negedge clock);
        bus_if.cpu_request_ready = 1'b0;
        check({nm, "_busy"}, 64'(bus_if.cpu_busy), 64'd1);
        if (mode == 3) begin
            bus_if.invalidate_address = a;
            bus_if.invalidate_valid   = 1'b1;
            if (m_valid[idx] && m_tag[idx] == a[15:8]) m_valid[idx] = 1'b0;
        end
        hit = m_valid[idx] && m_tag[idx] == a[15:8];
        if (hit) m_hits++;
        else m_misses++;
        @(negedge clock);
        bus_if.invalidate_valid = 1'b0;
        if (!wr && exp_hit) begin
            check({nm, "_hit_pulse"}, 64'(bus_if.data_out_ready), 64'd1);
            check({nm, "_hit_data"}, 64'(bus_if.data_out), 64'(exp_data));
            check({nm, "_hit_nomem"}, 64'(bus_if.memory_request_ready), 64'd0);
            last_dout = exp_data;
        end else begin
            check({nm, "_mreq_rdy"}, 64'(bus_if.memory_request_ready), 64'd1);
            check({nm, "_mreq"}, 64'(bus_if.memory_request), 64'(exp_req));
            for (int i = 0; i <= lat; i++) begin
                bus_if.invalidate_address = a;
                bus_if.invalidate_valid   = (mode == 1 && i == 0) || (mode == 2 && i == lat);
                if (i == lat) begin
                    bus_if.memory_response = wr ? 16'($urandom)
                                                : {mem[{a[15:1], 1'b1}], mem[{a[15:1], 1'b0}]};
                    bus_if.memory_response_ready = 1'b1;
                end
                @(negedge clock);
                bus_if.invalidate_valid      = 1'b0;
                bus_if.memory_response_ready = 1'b0;
                if (i < lat) begin
                    check({nm, "_hold_rdy"}, 64'(bus_if.memory_request_ready), 64'd1);
                    check({nm, "_hold_req"}, 64'(bus_if.memory_request), 64'(exp_req));
                    check({nm, "_no_early"}, 64'(bus_if.data_out_ready), 64'd0);
                end
            end
            check({nm, "_done_pulse"}, 64'(bus_if.data_out_ready), 64'd1);
            check({nm, "_done_data"}, 64'(bus_if.data_out), 64'(exp_data));
            check({nm, "_mreq_drop"}, 64'(bus_if.memory_request_ready), 64'd0);
            if (wr) begin
                mem[a] = d;
                if (hit) m_line[idx][a[0]] = d;
            end else begin
                m_tag[idx]     = a[15:8];
                m_line[idx][0] = mem[{a[15:1], 1'b0}];
                m_line[idx][1] = mem[{a[15:1], 1'b1}];
                m_valid[idx]   = (mode == 0 || mode == 3);
                last_dout      = exp_data;
            end
        end
        @(negedge clock);
        check({nm, "_pulse_end"}, 64'(bus_if.data_out_ready), 64'd0);
    endtask

    // Random address from a small tag/index pool so lines collide and hit often.
    function automatic logic [15:0] rand_addr();
        logic [7:0] tags [3];
        tags[0] = 8'h12;
        tags[1] = 8'h34;
        tags[2] = 8'h56;
        return {tags[$urandom_range(0, 2)], 7'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
    endfunction

    vec_t vecs [6];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h1234] = 8'hEF;
        mem[16'h1235] = 8'hBE;
        model_reset();
        bus_if.cpu_request           = '0;
        bus_if.cpu_request_ready     = 1'b0;
        bus_if.invalidate_address    = '0;
        bus_if.invalidate_valid      = 1'b0;
        bus_if.memory_response       = '0;
        bus_if.memory_response_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_busy", 64'(bus_if.cpu_busy), 64'd0);
        check("rst_mreq", 64'(bus_if.memory_request), 64'd0);
        check("rst_mreq_rdy", 64'(bus_if.memory_request_ready), 64'd0);
        check("rst_dout", 64'(bus_if.data_out), 64'd0);
        check("rst_dout_rdy", 64'(bus_if.data_out_ready), 64'd0);
        check_stats("rst");

        vecs[0] = '{1'b0, 8'h00, 16'h1234, 2, 1'b0, 8'hEF, 25'h0001234};
        vecs[1] = '{1'b0, 8'h00, 16'h1235, 0, 1'b1, 8'hBE, 25'h0000000};
        vecs[2] = '{1'b1, 8'h55, 16'h1235, 1, 1'b1, 8'hBE, 25'h1551235};
        vecs[3] = '{1'b0, 8'h00, 16'h1235, 0, 1'b1, 8'h55, 25'h0000000};
        vecs[4] = '{1'b1, 8'hAA, 16'h2000, 0, 1'b0, 8'h55, 25'h1AA2000};
        vecs[5] = '{1'b0, 8'h00, 16'h2000, 3, 1'b0, 8'hAA, 25'h0002000};
        for (int i = 0; i < 6; i++) begin
            transact($sformatf("vec%0d", i), vecs[i].wr, vecs[i].d, vecs[i].a, vecs[i].lat, 0,
                     vecs[i].exp_hit, vecs[i].exp_data, vecs[i].exp_req);
            if (i == 1) check_stats("vec1_stats");
        end
        check_stats("vec_stats");

        snoop(16'h1234);
        transact("inv_miss", 1'b0, 8'h00, 16'h1235, 1, 0, 1'b0, 8'h55, 25'h0001235);
        snoop(16'h7734);
        transact("inv_other_tag", 1'b0, 8'h00, 16'h1234, 0, 0, 1'b1, 8'hEF, 25'h0);
        transact("inv_wait", 1'b0, 8'h00, 16'h3000, 2, 1, 1'b0, mem[16'h3000], 25'h0003000);
        transact("inv_wait_re", 1'b0, 8'h00, 16'h3000, 0, 0, 1'b0, mem[16'h3000], 25'h0003000);
        transact("inv_fill", 1'b0, 8'h00, 16'h3002, 1, 2, 1'b0, mem[16'h3002], 25'h0003002);
        transact("inv_fill_re", 1'b0, 8'h00, 16'h3003, 0, 0, 1'b0, mem[16'h3003], 25'h0003003);
        transact("inv_lookup", 1'b0, 8'h00, 16'h3000, 0, 3, 1'b0, mem[16'h3000], 25'h0003000);
        transact("inv_lookup_re", 1'b0, 8'h00, 16'h3001, 0, 0, 1'b1, mem[16'h3001], 25'h0);
        check_stats("snoop_stats");

        // Reset while a read miss is outstanding, then a late response in IDLE.
        bus_if.cpu_request       = {1'b0, 8'h00, 16'h5000};
        bus_if.cpu_request_ready = 1'b1;
        @(negedge clock);
        bus_if.cpu_request_ready = 1'b0;
        @(negedge clock);
        check("rw_pending", 64'(bus_if.memory_request_ready), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check("rw_rst_mreq_rdy", 64'(bus_if.memory_request_ready), 64'd0);
        check("rw_rst_busy", 64'(bus_if.cpu_busy), 64'd0);
        bus_if.memory_response       = 16'hDEAD;
        bus_if.memory_response_ready = 1'b1;
        @(negedge clock);
        bus_if.memory_response_ready = 1'b0;
        check("late_resp_pulse", 64'(bus_if.data_out_ready), 64'd0);
        check("late_resp_busy", 64'(bus_if.cpu_busy), 64'd0);
        check("late_resp_dout", 64'(bus_if.data_out), 64'd0);
        check_stats("rw_rst_stats");
        transact("post_rst", 1'b0, 8'h00, 16'h1234, 0, 0, 1'b0, 8'hEF, 25'h0001234);

        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            bit          wr, hit;
            int          mode;
            if ($urandom_range(0, 3) == 0) snoop(rand_addr());
            a    = rand_addr();
            d    = 8'($urandom);
            wr   = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 9) == 0) ? 3 : 0;
            hit  = (mode != 3) && m_valid[a[7:1]] && m_tag[a[7:1]] == a[15:8];
            if (!wr && !hit && mode == 0 && $urandom_range(0, 4) == 0)
                mode = $urandom_range(1, 2);
            transact($sformatf("rnd%0d", n), wr, d, a, $urandom_range(0, 3), mode, hit,
                     wr ? last_dout : (hit ? m_line[a[7:1]][a[0]] : mem[a]),
                     wr ? {1'b1, d, a} : {1'b0, 8'h00, a});
        end
        check_stats("rnd_stats");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
